// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and helpers for the clock-gate enable controller.
package clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } cg_state_e;

  // Bits needed to hold values 0..max_val inclusive (never less than one).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a synchronous clear takes priority over an increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/clock_gate_enable_controller.sv
// Drives the clock-gating cell enable: gates after a run of idle cycles, and
// on wake holds off the acknowledge until the gate's synchroniser has settled.
module clock_gate_enable_controller
  import clock_gate_ctrl_pkg::*;
#(
  parameter int IDLE_THRESHOLD = 16,
  parameter int WAKE_LATENCY   = 2,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  activity,
  input  logic                  wake_req,
  input  logic                  force_on,
  input  logic                  stat_clr,
  output logic                  gate_enable,
  output logic                  wake_ack,
  output logic                  gated,
  output logic [STAT_WIDTH-1:0] gated_cycles
);

  localparam int IW = cnt_width(IDLE_THRESHOLD);
  localparam int WW = cnt_width(WAKE_LATENCY);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_THRESHOLD - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_LATENCY - 1);

  cg_state_e     state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WW-1:0] wake_cnt_q, wake_cnt_d;
  logic          gate_enable_q, gate_enable_d;
  logic          gated_q, gated_d;
  logic          wake_ack_q, wake_ack_d;
  logic          busy;

  assign busy = activity | wake_req | force_on;

  always_comb begin
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    wake_cnt_d    = wake_cnt_q;
    gate_enable_d = gate_enable_q;
    gated_d       = gated_q;

    case (state_q)
      RUN: begin
        if (busy) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d       = GATED;
          gate_enable_d = 1'b0;
          gated_d       = 1'b1;
          idle_cnt_d    = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end

      GATED: begin
        if (busy) begin
          state_d       = WAKE;
          gate_enable_d = 1'b1;
          gated_d       = 1'b0;
          wake_cnt_d    = '0;
        end
      end

      WAKE: begin
        // The wake always runs to completion so the synchroniser sees a
        // stable high enable before the requester is released.
        wake_cnt_d = wake_cnt_q + WW'(1);
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end
      end

      default: begin
        state_d       = RUN;
        gate_enable_d = 1'b1;
        gated_d       = 1'b0;
        idle_cnt_d    = '0;
        wake_cnt_d    = '0;
      end
    endcase

    wake_ack_d = (state_d == RUN) & wake_req;
  end

  // Reset forces the enable high immediately so a gated clock restarts
  // without waiting for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      idle_cnt_q    <= '0;
      wake_cnt_q    <= '0;
      gate_enable_q <= 1'b1;
      gated_q       <= 1'b0;
      wake_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      gate_enable_q <= gate_enable_d;
      gated_q       <= gated_d;
      wake_ack_q    <= wake_ack_d;
    end
  end

  sat_counter #(
    .WIDTH(STAT_WIDTH)
  ) u_gated_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (state_q == GATED),
    .clr_i  (stat_clr),
    .count_o(gated_cycles)
  );

  assign gate_enable = gate_enable_q;
  assign gated       = gated_q;
  assign wake_ack    = wake_ack_q;

endmodule

// File: doc/clock_gate_enable_controller.md
Name: clock_gate_enable_controller

Overview:
Generates the enable input of the downstream clock-gating cell from activity and wake requests. Runs on the free-running clock. After IDLE_THRESHOLD consecutive idle cycles it drops gate_enable. On a wake event it re-raises gate_enable and holds off acknowledging until the gate's synchroniser has propagated it. It also keeps a saturating count of gated cycles for power telemetry.

Parameters:
IDLE_THRESHOLD, 16, consecutive idle cycles before gating; legal range 1..65535
WAKE_LATENCY, 2, cycles gate_enable must be high before wake_ack is allowed; set equal to the gate's sync STAGES; legal range >=1
STAT_WIDTH, 16, width of the gated-cycle statistics counter

Ports:
clk  input  1  free-running (ungated) clock
rst_n  input  1  asynchronous active-low reset
activity  input  1  level; 1 = downstream logic busy this cycle
wake_req  input  1  four-phase wake request; held until wake_ack
force_on  input  1  forces clock on; treated as activity
stat_clr  input  1  synchronous clear of gated_cycles
gate_enable  output  1  registered enable to the clock-gating cell
wake_ack  output  1  four-phase acknowledge
gated  output  1  1 while in GATED state
gated_cycles  output  STAT_WIDTH  saturating count of cycles spent in GATED

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, gate_enable=1, wake_ack=0, gated=0, idle_cnt=0, wake_cnt=0, gated_cycles=0.
  - gate_enable rises immediately on reset assertion, including mid-GATED.
- busy = activity | wake_req | force_on, sampled each posedge.
- States: RUN, GATED, WAKE. All outputs are registered.
- RUN (gate_enable=1):
  - busy=1: idle_cnt<=0.
  - busy=0 and idle_cnt==IDLE_THRESHOLD-1: go to GATED, gate_enable<=0, gated<=1, idle_cnt<=0.
  - busy=0 otherwise: idle_cnt<=idle_cnt+1.
  - Net effect: gate_enable falls on the IDLE_THRESHOLD-th consecutive idle edge.
  - IDLE_THRESHOLD=1 gates on the first idle edge.
- GATED (gate_enable=0):
  - gated_cycles increments once per cycle, saturating at all-ones.
  - busy=1: go to WAKE, gate_enable<=1, gated<=0, wake_cnt<=0.
  - Total wake latency, busy sampled to gate_enable high: 1 cycle.
- WAKE (gate_enable=1):
  - wake_cnt<=wake_cnt+1.
  - When wake_cnt==WAKE_LATENCY-1: go to RUN, idle_cnt<=0.
  - Idle inputs during WAKE do not abort the wake. RUN is always re-entered before gating can recur.
- wake_ack:
  - Next-state value = (next state is RUN) & wake_req.
  - Falls one cycle after wake_req drops.
  - Never asserted in GATED or WAKE.
  - wake_req already high while in RUN is acked on the next edge.
- Simultaneous events:
  - busy on the same edge the threshold would be hit: stay RUN, idle_cnt<=0.
  - stat_clr together with an increment: clear wins, gated_cycles<=0.
  - wake_req dropped before ack: no ack. Requester protocol violation; the controller tolerates it.
- idle_cnt width = $clog2(IDLE_THRESHOLD+1); wake_cnt width = $clog2(WAKE_LATENCY+1).
- Invariants:
  - gate_enable == !gated.
  - gate_enable changes only on posedge clk or on reset assertion; it is glitch-free by construction.

Decomposition:
- Package clock_gate_ctrl_pkg: state enum (RUN=2'd0, GATED=2'd1, WAKE=2'd2) and a function computing counter widths.
- One natural sub-module, sat_counter (parameterised width, inc, clr, clr-over-inc priority), instantiated for gated_cycles.
- The FSM and idle/wake counters stay in the top module.

Test Plan:
1. Reset then activity=0, wake_req=0, force_on=0 with defaults:
   - gate_enable=1 after 15 edges; gate_enable=0, gated=1 on the 16th edge.
   - gated_cycles then counts 1,2,3...
2. Idle for 15 cycles, activity=1 on the 16th edge:
   - gate_enable stays 1 and idle_cnt resets.
   - A further 16 idle cycles are needed to gate.
3. While GATED, raise wake_req and hold it:
   - gate_enable=1 on the next edge.
   - wake_ack=1 exactly 2 edges later (WAKE_LATENCY=2).
   - Drop wake_req: wake_ack=0 one edge later.
   - 16 more idle cycles: gated again.
4. While GATED, pulse force_on for 1 cycle:
   - WAKE, then RUN.
   - No wake_ack.
   - Re-gates after 16 idle cycles.
5. STAT_WIDTH=4, stay GATED 20 cycles:
   - gated_cycles saturates at 15.
   - Assert stat_clr during an increment cycle: gated_cycles=0 next edge.
6. Assert rst_n=0 mid-GATED and mid-WAKE:
   - gate_enable=1 and wake_ack=0 immediately, without a clock edge.
   - After release, gating requires a full 16 idle cycles.
